// File: rtl/lut_mult_pkg.sv
// Shared types and widths for the LUT multiplier checker and its golden engine.
package lut_mult_pkg;

    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned OVR_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        COMPARE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add_mult32.sv
// Sequential radix-2 shift-add multiplier: one multiplier bit per clock, LSB first.
module shift_add_mult32
    import lut_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] acc,
    output logic              valid,
    output logic              last
);

    localparam logic [4:0] LAST_ITER = 5'(OP_W - 1);

    logic [PROD_W-1:0] acc_q, acc_d;
    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [OP_W-1:0]   mplier_q, mplier_d;
    logic [4:0]        iter_q, iter_d;
    logic              run_q, run_d;
    logic              valid_q, valid_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        iter_d   = iter_q;
        run_d    = run_q;
        valid_d  = valid_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{(PROD_W-OP_W){1'b0}}, a};
            mplier_d = b;
            iter_d   = '0;
            run_d    = 1'b1;
            valid_d  = 1'b0;
        end else if (run_q) begin
            // Multiplicand is held 64 bits wide so the shifted partial sum never truncates
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            iter_d   = iter_q + 5'd1;
            if (iter_q == LAST_ITER) begin
                run_d   = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            iter_q   <= '0;
            run_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            iter_q   <= iter_d;
            run_q    <= run_d;
            valid_q  <= valid_d;
        end
    end

    assign acc   = acc_q;
    assign valid = valid_q;
    assign last  = run_q && (iter_q == LAST_ITER);

endmodule

// File: rtl/lut_mult_32b_checker.sv
// Self-checking receiver: golden shift-add product vs. multiplier output sampled after LATENCY edges.
module lut_mult_32b_checker
    import lut_mult_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk_32b,
    input  logic              resetn_32b,
    input  logic              op_valid,
    input  logic [OP_W-1:0]   source_number_32b_0,
    input  logic [OP_W-1:0]   source_number_32b_1,
    input  logic [PROD_W-1:0] result_64b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [PROD_W-1:0] expected_64b,
    output logic [CNT_W-1:0]  check_count,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [OVR_W-1:0]  overrun_count
);

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [7:0]        lat_q, lat_d;
    logic              cap_q, cap_d;
    logic [PROD_W-1:0] dut_q, dut_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic [PROD_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0]  chk_q, chk_d;
    logic [CNT_W-1:0]  mis_q, mis_d;
    logic [OVR_W-1:0]  ovr_q, ovr_d;

    logic              eng_start;
    logic [PROD_W-1:0] eng_acc;
    logic              eng_valid;
    logic              eng_last;
    logic              cap_now;
    logic              match;

    assign eng_start = (state_q == IDLE) && op_valid;
    assign cap_now   = (state_q == RUN) && !cap_q && (lat_q == LAT_M1);
    assign match     = (eng_acc == dut_q);

    shift_add_mult32 u_golden (
        .clk   (clk_32b),
        .rst_n (resetn_32b),
        .start (eng_start),
        .a     (source_number_32b_0),
        .b     (source_number_32b_1),
        .acc   (eng_acc),
        .valid (eng_valid),
        .last  (eng_last)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        cap_d   = cap_q;
        dut_d   = dut_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        exp_d   = exp_q;
        chk_d   = chk_q;
        mis_d   = mis_q;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    lat_d   = '0;
                    cap_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (lat_q != '1) begin
                    lat_d = lat_q + 8'd1;
                end
                if (cap_now) begin
                    dut_d = result_64b;
                    cap_d = 1'b1;
                end
                // Look at this edge's completions too, so COMPARE lands exactly one edge after both
                if ((eng_valid || eng_last) && (cap_q || cap_now)) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                pass_d  = match;
                exp_d   = eng_acc;
                done_d  = 1'b1;
                state_d = IDLE;
                if (chk_q != '1) begin
                    chk_d = chk_q + CNT_W'(1);
                end
                if (!match && (mis_q != '1)) begin
                    mis_d = mis_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && op_valid && (ovr_q != '1)) begin
            ovr_d = ovr_q + OVR_W'(1);
        end
    end

    always_ff @(posedge clk_32b or negedge resetn_32b) begin
        if (!resetn_32b) begin
            state_q <= IDLE;
            lat_q   <= '0;
            cap_q   <= 1'b0;
            dut_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            exp_q   <= '0;
            chk_q   <= '0;
            mis_q   <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cap_q   <= cap_d;
            dut_q   <= dut_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            exp_q   <= exp_d;
            chk_q   <= chk_d;
            mis_q   <= mis_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign pass           = pass_q;
    assign expected_64b   = exp_q;
    assign check_count    = chk_q;
    assign mismatch_count = mis_q;
    assign overrun_count  = ovr_q;

endmodule
